// File: rtl/unidade_acesso_memoria_if.sv
// unidade_acesso_memoria_if: core request/response and data-memory port bundle.
// slave is the access unit's view; master is the core plus memory side.
interface unidade_acesso_memoria_if #(
  parameter int LARGURA_END  = 8,
  parameter int LARGURA_DADO = 8
);
  logic                    Requisicao;
  logic [1:0]              Operacao;
  logic [LARGURA_END-1:0]  EnderecoA;
  logic [LARGURA_END-1:0]  EnderecoB;
  logic [LARGURA_END-1:0]  Quantidade;
  logic [LARGURA_DADO-1:0] DadoEntrada;
  logic [LARGURA_DADO-1:0] DadoSaida;
  logic                    Ocupado;
  logic                    Pronto;
  logic                    Erro;
  logic [LARGURA_END-1:0]  Endereco;
  logic [LARGURA_DADO-1:0] DadoEscrito;
  logic                    EscMem;
  logic                    LerMem;
  logic [LARGURA_DADO-1:0] DadoLido;
  modport master (
    output Requisicao, Operacao, EnderecoA, EnderecoB, Quantidade, DadoEntrada, DadoLido,
    input  DadoSaida, Ocupado, Pronto, Erro, Endereco, DadoEscrito, EscMem, LerMem
  );
  modport slave (
    input  Requisicao, Operacao, EnderecoA, EnderecoB, Quantidade, DadoEntrada, DadoLido,
    output DadoSaida, Ocupado, Pronto, Erro, Endereco, DadoEscrito, EscMem, LerMem
  );
endinterface

// File: rtl/unidade_acesso_memoria.sv
// unidade_acesso_memoria: sequences load/store/block-copy requests onto the data-memory port.
// Block copy is compiled in only when UNIDADE_ACESSO_COPIA_EN is defined.
module unidade_acesso_memoria #(
  parameter int LARGURA_END  = 8,
  parameter int LARGURA_DADO = 8
) (
  input logic                    Clock,
  input logic                    Reset,
  unidade_acesso_memoria_if.slave bus
);
  typedef enum logic [2:0] {OCIOSO, LEITURA, ESCRITA, COPIA_LE, COPIA_ESCREVE} estado_t;
  estado_t                 estado_q;
  logic [LARGURA_DADO-1:0] dado_saida_q, dado_escrito_q;
  logic [LARGURA_END-1:0]  endereco_q;
  logic                    ocupado_q, pronto_q, erro_q, esc_q, ler_q;
`ifdef UNIDADE_ACESSO_COPIA_EN
  logic [LARGURA_END-1:0]  a_q, b_q, cnt_q;
`else
  logic                    unused_copia;
  assign unused_copia = ^{bus.EnderecoB, bus.Quantidade};
`endif
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      estado_q       <= OCIOSO;
      dado_saida_q   <= '0;
      dado_escrito_q <= '0;
      endereco_q     <= '0;
      ocupado_q      <= 1'b0;
      pronto_q       <= 1'b0;
      erro_q         <= 1'b0;
      esc_q          <= 1'b0;
      ler_q          <= 1'b0;
`ifdef UNIDADE_ACESSO_COPIA_EN
      a_q            <= '0;
      b_q            <= '0;
      cnt_q          <= '0;
`endif
    end else begin
      pronto_q <= 1'b0;
      erro_q   <= 1'b0;
      case (estado_q)
        OCIOSO: if (bus.Requisicao) begin
          ocupado_q  <= 1'b1;
          endereco_q <= bus.EnderecoA;
          if (bus.Operacao == 2'b00) begin
            estado_q <= LEITURA;
            ler_q    <= 1'b1;
          end else if (bus.Operacao == 2'b01) begin
            estado_q       <= ESCRITA;
            esc_q          <= 1'b1;
            dado_escrito_q <= bus.DadoEntrada;
`ifdef UNIDADE_ACESSO_COPIA_EN
          end else if (bus.Operacao == 2'b10) begin
            a_q      <= bus.EnderecoA + 1'b1;
            b_q      <= bus.EnderecoB;
            cnt_q    <= bus.Quantidade;
            ler_q    <= bus.Quantidade != '0;
            estado_q <= bus.Quantidade == '0 ? COPIA_ESCREVE : COPIA_LE;
`endif
          end else begin
            // rejected op idles one cycle in ESCRITA with strobes low, which flags Erro there
            estado_q <= ESCRITA;
          end
        end
        LEITURA: begin
          dado_saida_q <= bus.DadoLido;
          ler_q        <= 1'b0;
          pronto_q     <= 1'b1;
          ocupado_q    <= 1'b0;
          estado_q     <= OCIOSO;
        end
        ESCRITA: begin
          esc_q     <= 1'b0;
          pronto_q  <= esc_q;
          erro_q    <= !esc_q;
          ocupado_q <= 1'b0;
          estado_q  <= OCIOSO;
        end
`ifdef UNIDADE_ACESSO_COPIA_EN
        COPIA_LE: begin
          dado_escrito_q <= bus.DadoLido;
          endereco_q     <= b_q;
          b_q            <= b_q + 1'b1;
          ler_q          <= 1'b0;
          esc_q          <= 1'b1;
          estado_q       <= COPIA_ESCREVE;
        end
        COPIA_ESCREVE: begin
          esc_q <= 1'b0;
          cnt_q <= cnt_q - 1'b1;
          // cnt_q of 0 or 1 both end the copy: 0 is the empty copy entered straight here
          if (cnt_q[LARGURA_END-1:1] == '0) begin
            pronto_q  <= 1'b1;
            ocupado_q <= 1'b0;
            estado_q  <= OCIOSO;
          end else begin
            endereco_q <= a_q;
            a_q        <= a_q + 1'b1;
            ler_q      <= 1'b1;
            estado_q   <= COPIA_LE;
          end
        end
`endif
        default: estado_q <= OCIOSO;
      endcase
    end
  end
  assign bus.DadoSaida   = dado_saida_q;
  assign bus.DadoEscrito = dado_escrito_q;
  assign bus.Endereco    = endereco_q;
  assign bus.Ocupado     = ocupado_q;
  assign bus.Pronto      = pronto_q;
  assign bus.Erro        = erro_q;
  assign bus.EscMem      = esc_q;
  assign bus.LerMem      = ler_q;
endmodule

// File: doc/unidade_acesso_memoria.md
# unidade_acesso_memoria

Memory-side initiator for the 8-bit data memory: accepts load, store and (optionally) block-copy requests from the datapath and sequences the memory's EscMem/LerMem/Endereco/DadoEscrito port. It captures read data that the memory produces on the falling edge of Clock and reports completion with a one-cycle pulse. It sits between the core's execute stage and the data memory, so the memory's edge behaviour is hidden from the core.

## Interface
- LARGURA_END, 8, address width; also the width of Quantidade
- LARGURA_DADO, 8, data width
- Clock  in  1  system clock; all state changes on rising edge
- Reset  in  1  asynchronous, active-high; clears all state and outputs
- Requisicao  in  1  request valid (level)
- Operacao  in  2  00 load, 01 store, 10 block copy, 11 reserved
- EnderecoA  in  LARGURA_END  load/store address; copy source base
- EnderecoB  in  LARGURA_END  copy destination base
- Quantidade  in  LARGURA_END  copy byte count
- DadoEntrada  in  LARGURA_DADO  store data
- DadoSaida  out  LARGURA_DADO  last loaded byte, held
- Ocupado  out  1  operation in progress
- Pronto  out  1  one-cycle completion pulse
- Erro  out  1  one-cycle pulse for rejected operation
- Endereco  out  LARGURA_END  to memory
- DadoEscrito  out  LARGURA_DADO  to memory
- EscMem  out  1  to memory; memory writes on the next rising edge
- LerMem  out  1  to memory; memory reads on the falling edge of the same cycle
- DadoLido  in  LARGURA_DADO  from memory

## Operation
- All outputs are registered. FSM states: OCIOSO, LEITURA, ESCRITA, COPIA_LE, COPIA_ESCREVE.
- Acceptance happens only in OCIOSO, on an edge with Requisicao=1.
  - Operacao, EnderecoA, EnderecoB, Quantidade and DadoEntrada are latched at acceptance.
  - Later input changes have no effect on the accepted operation.
- Requisicao while Ocupado=1 is ignored; there is no queueing.
  - The core drops Requisicao once it sees Ocupado=1. If Requisicao is still high in OCIOSO, it is a new request.
- Load: OCIOSO→LEITURA, driving Endereco=A and LerMem=1. At the next edge: DadoSaida←DadoLido, LerMem=0, Pronto=1, →OCIOSO.
- Store: OCIOSO→ESCRITA, driving Endereco=A, DadoEscrito=D and EscMem=1. At the next edge: EscMem=0, Pronto=1, →OCIOSO.
- Copy, per byte i (i=0..Quantidade-1):
  - COPIA_LE drives Endereco=A+i and LerMem=1.
  - At the next edge: capture DadoLido, →COPIA_ESCREVE, driving Endereco=B+i, DadoEscrito=captured byte, EscMem=1, LerMem=0.
  - At the next edge: the next byte's COPIA_LE, or Pronto=1 and →OCIOSO after the last byte.
- Copy ordering and addressing:
  - Strictly forward order. Byte i is written before byte i+1 is read, so overlapping regions with B>A replicate the source pattern.
  - Address arithmetic is modulo 2^LARGURA_END; both pointers wrap 255→0.
  - Quantidade=0: no memory access; Pronto=1 on the edge after acceptance.
- Operacao=11: no memory access; Erro=1 (Pronto stays 0) on the edge after acceptance; →OCIOSO.
- EscMem and LerMem are never both 1. Both are 0 in OCIOSO.
- DadoSaida changes only on load completion. Store and copy leave it unchanged.
- Reset, any time: state OCIOSO.
  - All outputs go to 0: DadoSaida, Ocupado, Pronto, Erro, Endereco, DadoEscrito, EscMem, LerMem.
  - An in-flight copy is abandoned. Bytes already written remain in memory.

## Timing
- Ocupado=1 from the acceptance edge until the completion edge. Ocupado falls on the same edge where Pronto/Erro rises.
- Load latency: Pronto high in the 2nd cycle after acceptance; DadoSaida is valid in that same cycle.
- Store latency: Pronto high in the 2nd cycle after acceptance; memory is updated at the edge that raises Pronto.
- Copy latency: 2·Quantidade cycles of memory activity, then Pronto; Quantidade=0 → Pronto in the 2nd cycle after acceptance.
- Back-to-back throughput: a new request is accepted at the edge that ends the Pronto cycle (one op per 2 cycles for load/store).
- Pronto and Erro are exactly one cycle wide.

## Configuration
- UNIDADE_ACESSO_COPIA_EN defined: block copy is supported as described above.
- Not defined: the copy states and EnderecoB/Quantidade logic are compiled out.
  - Operacao=10 is treated exactly like 11 (Erro pulse, no memory access).
  - EnderecoB and Quantidade are ignored.

## Test plan
- Reset, then store 0x5A to 0x10 and load 0x10 → EscMem one cycle with Endereco=0x10; then Pronto pulses with DadoSaida=0x5A two cycles after load acceptance.
- Requisicao held high during a load, with EnderecoA changed mid-op → only the latched address is read; a second load is accepted at the Pronto-ending edge.
- Copy A=0xFE, B=0x20, Quantidade=4, with mem[FE,FF,00,01]=11,22,33,44 → mem[20..23]=11,22,33,44; Pronto after 8 cycles; pointer wraps.
- Overlapping copy A=0x40, B=0x41, Quantidade=3, mem[40]=0x7 → mem[41..43]=0x7; Quantidade=0 → Pronto with no EscMem/LerMem.
- Operacao=11, and Operacao=10 with the macro undefined → Erro one cycle, Pronto=0, no memory strobes.
- Reset asserted mid-copy after 2 bytes → outputs 0 immediately, first 2 destination bytes written, rest untouched; next load works normally.
